// File: rtl/cio_arbiter_if.sv
// cio_arbiter_if: bundle of the console I/O handshake between the core,
// the arbiter and the two character endpoints (host stream, front panel).
//   core side   : Cout, CinReq, CoutData -> arbiter; CioAcq, CinData <- arbiter
//   sink side   : out_data, host/panel_out_valid <- arbiter; host/panel_out_ack -> arbiter
//   source side : host/panel_in_valid, host/panel_in_data -> arbiter; host/panel_in_ack <- arbiter
//   control     : sink_enable -> arbiter; busy, timeout <- arbiter
// Modport slave is the arbiter's view, master is the environment's view.
interface cio_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Cout;
    logic                  CinReq;
    logic [DATA_WIDTH-1:0] CoutData;
    logic                  CioAcq;
    logic [DATA_WIDTH-1:0] CinData;
    logic [1:0]            sink_enable;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  host_out_valid;
    logic                  panel_out_valid;
    logic                  host_out_ack;
    logic                  panel_out_ack;
    logic                  host_in_valid;
    logic                  panel_in_valid;
    logic [DATA_WIDTH-1:0] host_in_data;
    logic [DATA_WIDTH-1:0] panel_in_data;
    logic                  host_in_ack;
    logic                  panel_in_ack;
    logic                  busy;
    logic                  timeout;

    modport slave (
        input  Cout, CinReq, CoutData, sink_enable,
        input  host_out_ack, panel_out_ack,
        input  host_in_valid, panel_in_valid, host_in_data, panel_in_data,
        output CioAcq, CinData, out_data,
        output host_out_valid, panel_out_valid,
        output host_in_ack, panel_in_ack, busy, timeout
    );

    modport master (
        output Cout, CinReq, CoutData, sink_enable,
        output host_out_ack, panel_out_ack,
        output host_in_valid, panel_in_valid, host_in_data, panel_in_data,
        input  CioAcq, CinData, out_data,
        input  host_out_valid, panel_out_valid,
        input  host_in_ack, panel_in_ack, busy, timeout
    );
endinterface

// File: rtl/cio_arbiter.sv
// cio_arbiter: console I/O arbiter between the DekatronPC core and two
// character endpoints. Output characters are broadcast to every enabled sink;
// the core is acknowledged once all enabled sinks accepted or a timeout hits.
// Input requests are granted to one source at a time, round-robin on ties.
// Ports:
//   Clk    system clock, rising edge
//   Rst_n  asynchronous active-low reset
//   cio    cio_arbiter_if.slave bundle (core, sink, source and status signals)
// All outputs are registered (busy is a decode of the state register).
module cio_arbiter #(
    parameter int          DATA_WIDTH     = 8,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic         Clk,
    input  logic         Rst_n,
    cio_arbiter_if.slave cio
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_OUT_WAIT,
        S_IN_WAIT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] cin_data_q, cin_data_d;
    // Two-bit masks: bit0 = host, bit1 = panel.
    logic [1:0]            en_mask_q, en_mask_d;
    logic [1:0]            done_mask_q, done_mask_d;
    logic [1:0]            out_valid_q, out_valid_d;
    logic [1:0]            in_ack_q, in_ack_d;
    logic                  acq_q, acq_d;
    logic                  timeout_q, timeout_d;
    logic                  last_grant_q, last_grant_d;   // 1 = panel
    logic [15:0]           timer_q, timer_d;

    logic [1:0]            new_ack;
    logic [1:0]            covered;
    logic [1:0]            in_valid;

    // An ack counts only while that sink's valid is up; valid is only ever
    // raised for enabled sinks, so disabled-sink acks fall out here too.
    assign new_ack  = out_valid_q & {cio.panel_out_ack, cio.host_out_ack};
    assign covered  = done_mask_q | new_ack;
    assign in_valid = {cio.panel_in_valid, cio.host_in_valid};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            out_data_q   <= '0;
            cin_data_q   <= '0;
            en_mask_q    <= '0;
            done_mask_q  <= '0;
            out_valid_q  <= '0;
            in_ack_q     <= '0;
            acq_q        <= 1'b0;
            timeout_q    <= 1'b0;
            last_grant_q <= 1'b1;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            cin_data_q   <= cin_data_d;
            en_mask_q    <= en_mask_d;
            done_mask_q  <= done_mask_d;
            out_valid_q  <= out_valid_d;
            in_ack_q     <= in_ack_d;
            acq_q        <= acq_d;
            timeout_q    <= timeout_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        cin_data_d   = cin_data_q;
        en_mask_d    = en_mask_q;
        done_mask_d  = done_mask_q;
        out_valid_d  = out_valid_q;
        in_ack_d     = '0;
        acq_d        = 1'b0;
        timeout_d    = 1'b0;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;

        case (state_q)
            S_IDLE: begin
                if (cio.Cout) begin
                    out_data_d  = cio.CoutData;
                    en_mask_d   = cio.sink_enable;
                    done_mask_d = '0;
                    timer_d     = '0;
                    if (cio.sink_enable != 2'b00) begin
                        out_valid_d = cio.sink_enable;
                        state_d     = S_OUT_WAIT;
                    end else begin
                        // CioAcq is registered, so it is raised on entry to ACK.
                        acq_d   = 1'b1;
                        state_d = S_ACK;
                    end
                end else if (cio.CinReq) begin
                    state_d = S_IN_WAIT;
                end
            end

            S_OUT_WAIT: begin
                done_mask_d = covered;
                out_valid_d = out_valid_q & ~new_ack;
                if ((covered & en_mask_q) == en_mask_q) begin
                    acq_d   = 1'b1;
                    state_d = S_ACK;
                end else if (timer_q == TIMEOUT_CYCLES - 16'd1) begin
                    out_valid_d = '0;
                    acq_d       = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = S_ACK;
                end else if (timer_q != 16'hFFFF) begin
                    timer_d = timer_q + 16'd1;
                end
            end

            S_IN_WAIT: begin
                if (!cio.CinReq) begin
                    state_d = S_IDLE;
                end else if (in_valid != 2'b00) begin
                    // Panel wins if it is the only source, or on a tie when
                    // host had the previous grant.
                    if (in_valid == 2'b10 || (in_valid == 2'b11 && !last_grant_q)) begin
                        cin_data_d   = cio.panel_in_data;
                        in_ack_d     = 2'b10;
                        last_grant_d = 1'b1;
                    end else begin
                        cin_data_d   = cio.host_in_data;
                        in_ack_d     = 2'b01;
                        last_grant_d = 1'b0;
                    end
                    acq_d   = 1'b1;
                    state_d = S_ACK;
                end
            end

            S_ACK: begin
                state_d = S_RELEASE;
            end

            S_RELEASE: begin
                if (!cio.Cout && !cio.CinReq) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cio.CioAcq          = acq_q;
    assign cio.CinData         = cin_data_q;
    assign cio.out_data        = out_data_q;
    assign cio.host_out_valid  = out_valid_q[0];
    assign cio.panel_out_valid = out_valid_q[1];
    assign cio.host_in_ack     = in_ack_q[0];
    assign cio.panel_in_ack    = in_ack_q[1];
    assign cio.busy            = (state_q != S_IDLE);
    assign cio.timeout         = timeout_q;
endmodule
